mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter sharing the single unified instruction/data memory of the multicycle MIPS core between the CPU datapath (the IorD-selected address path sequenced by the control unit) and the program loader (UART boot/debug writer). Each access is a two-cycle issue/acknowledge transaction. The block stalls the CPU while the loader owns memory. Round-robin arbitration applies on contention, and loader bursts are bounded so the CPU cannot be starved.

## Interface
- ADDR_W, 32, memory byte-address width
- DATA_W, 32, memory data width
- MAX_BURST, 8, max back-to-back loader beats before a pending CPU request must be served (≥1)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  CPU write enable (qualified by cpu_req)
- cpu_addr  in  ADDR_W  CPU address (PC or ALUOut per IorD)
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data, valid when cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_ack; control FSM holds state while high
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack: loader port, same semantics and widths as the CPU port
- mem_addr  out  ADDR_W  to memory
- mem_wdata  out  DATA_W  to memory
- mem_we  out  1  memory write strobe, written at the clock edge ending the cycle
- mem_rdata  in  DATA_W  synchronous-read data, valid the cycle after the address is presented

## Operation
- FSM states: IDLE, C_ISSUE, C_ACK, L_ISSUE, L_ACK. Reset state is IDLE.
- Registers: last_grant (0=CPU, 1=LDR, reset 1), beat_cnt (reset 0, width clog2(MAX_BURST+1)).
- IDLE: only cpu_req → C_ISSUE. Only ldr_req → L_ISSUE, beat_cnt←0. Both → grant the side opposite last_grant. Neither → stay.
- X_ISSUE: mem_addr/mem_wdata/mem_we are driven combinationally from the granted port. Next state is X_ACK unconditionally.
- X_ACK: x_ack=1 and x_rdata=mem_rdata. last_grant←X.
- C_ACK → IDLE always.
- L_ACK: beat_cnt+1. Go to L_ISSUE (next beat) if ldr_req=1 and not (cpu_req=1 and beat_cnt+1 ≥ MAX_BURST). Otherwise go to IDLE.
- The loader keeps its grant past MAX_BURST while cpu_req=0.
- A requester seeing x_ack may change addr/data at that edge. If req stays high, that is a new transaction.
- Outside ISSUE states: mem_we=0, and mem_addr/mem_wdata are muxed from the port given by last_grant (don't-care).
- cpu_rdata/ldr_rdata pass mem_rdata at all times. They are meaningful only with ack.
- mem_we is gated by rst_n: no write occurs in a cycle where rst_n=0.
- Requesters must hold req/we/addr/wdata stable from assertion through ack. Dropping req before ack is a protocol violation; behaviour is undefined but recovers in IDLE.

## Timing
- Reset values: state IDLE, all acks 0, mem_we 0, cpu_stall = cpu_req (combinational).
- Latency, uncontended: req first sampled at edge N → ISSUE in cycle N..N+1 → ack high in cycle N+1..N+2.
  - Read data is therefore returned 2 cycles after req.
- Loader burst throughput: 1 beat per 2 cycles (ISSUE/ACK alternating, no IDLE bubble).
- CPU after a loader burst: worst-case wait = 2·MAX_BURST cycles + 2 cycles for its own access.
- Reset mid-transaction (rst_n=0 in any ISSUE/ACK): next state is IDLE, no ack pulse, no write. last_grant→1, beat_cnt→0.
- Simultaneous req rise in IDLE: resolved the same cycle by last_grant. There is no extra arbitration cycle.

## Test plan
- Reset, then CPU read only: cpu_addr=0x40, memory preloaded 0xDEADBEEF → cpu_ack 2 cycles after cpu_req, cpu_rdata=0xDEADBEEF, cpu_stall high exactly 2 cycles, mem_we never high.
- Loader write burst of 4 to 0x0..0xC with cpu_req=0 → 4 ldr_ack pulses at 2-cycle spacing, no IDLE between beats, memory holds the data afterward.
- Both req asserted in the same cycle after reset → CPU granted first (last_grant=1). Sustained contention then alternates CPU, LDR, CPU.
- MAX_BURST=8, loader streaming 20 beats, cpu_req rises during beat 3 → loader completes exactly beat 8, then C_ISSUE. CPU ack arrives within 2·8+2 cycles of cpu_req, then the loader resumes.
- rst_n pulled low during L_ISSUE of a write to 0x100 → mem_we=0 in that cycle, 0x100 unchanged, no ldr_ack, FSM in IDLE next cycle.
- CPU write (cpu_we=1, 0x20←0x12345678) followed by a loader read of 0x20 → ldr_rdata=0x12345678 on its ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single unified instruction/data memory between the
// CPU datapath and the program loader. Each access is an issue/ack pair of
// cycles. Contention is resolved round-robin. Loader bursts yield to a
// waiting CPU after MAX_BURST beats.
module mem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    // CPU port
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_stall_o,

    // Loader port
    input  logic              ldr_req_i,
    input  logic              ldr_we_i,
    input  logic [ADDR_W-1:0] ldr_addr_i,
    input  logic [DATA_W-1:0] ldr_wdata_i,
    output logic [DATA_W-1:0] ldr_rdata_o,
    output logic              ldr_ack_o,

    // Memory port
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned BeatW = $clog2(MAX_BURST + 1);
    localparam logic [BeatW-1:0] BurstMax = BeatW'(MAX_BURST);

    typedef enum logic [2:0] {
        StIdle,
        StCIssue,
        StCAck,
        StLIssue,
        StLAck
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;  // 0 = CPU, 1 = loader
    logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
    logic [BeatW-1:0] beat_inc;
    logic             sel_ldr;

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Next-state logic: arbitration, burst counting and bounded loader grant.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        // Saturate so an unopposed loader can stream indefinitely without wrap.
        beat_inc     = (beat_cnt_q >= BurstMax) ? beat_cnt_q : beat_cnt_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (cpu_req_i && ldr_req_i) begin
                    // Grant the side that was not served most recently.
                    if (last_grant_q) begin
                        state_d = StCIssue;
                    end else begin
                        state_d    = StLIssue;
                        beat_cnt_d = '0;
                    end
                end else if (cpu_req_i) begin
                    state_d = StCIssue;
                end else if (ldr_req_i) begin
                    state_d    = StLIssue;
                    beat_cnt_d = '0;
                end
            end
            StCIssue: state_d = StCAck;
            StCAck: begin
                last_grant_d = 1'b0;
                state_d      = StIdle;
            end
            StLIssue: state_d = StLAck;
            StLAck: begin
                last_grant_d = 1'b1;
                beat_cnt_d   = beat_inc;
                // Continue the burst unless a waiting CPU has hit the beat limit.
                if (ldr_req_i && !(cpu_req_i && (beat_inc >= BurstMax))) begin
                    state_d = StLIssue;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory-side mux: the issuing port drives memory, otherwise the last grantee.
    always_comb begin
        sel_ldr = last_grant_q;
        if (state_q == StCIssue) begin
            sel_ldr = 1'b0;
        end else if (state_q == StLIssue) begin
            sel_ldr = 1'b1;
        end
        mem_addr_o  = sel_ldr ? ldr_addr_i  : cpu_addr_i;
        mem_wdata_o = sel_ldr ? ldr_wdata_i : cpu_wdata_i;
        // Writes only in issue cycles, and never while reset is asserted.
        mem_we_o    = rst_ni &
                      (((state_q == StCIssue) & cpu_req_i & cpu_we_i) |
                       ((state_q == StLIssue) & ldr_req_i & ldr_we_i));
    end

    // Requester-side outputs: ack pulses suppressed in reset, read data passed through.
    always_comb begin
        cpu_ack_o   = rst_ni & (state_q == StCAck);
        ldr_ack_o   = rst_ni & (state_q == StLAck);
        cpu_stall_o = cpu_req_i & ~cpu_ack_o;
        cpu_rdata_o = mem_rdata_i;
        ldr_rdata_o = mem_rdata_i;
    end

endmodule
